updown_counter: RTL and testbench
=================================

Name: updown_counter

Overview:
- 8-bit synchronous up/down counter in the standard user-project wrapper pin-out: 8 dedicated inputs, 8 dedicated outputs, 8 bidirectional pins, plus ena, clock and reset.
- Control bits on ui_in select count enable, direction and parallel load.
- The live count is driven on uo_out.
- The bidirectional pins are inputs only and carry parallel-load data.

Parameters:
- WIDTH, 8, counter width; must equal the uo_out width in this wrapper.
- RESET_VALUE, 8'h00, count value loaded by reset.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- ena  input  1  design enable; when 0 the count holds.
- ui_in  input  8  [0] count_en, [1] up_down (1 = up, 0 = down), [2] load, [7:3] unused.
- uo_out  output  8  current count, registered.
- uio_in  input  8  parallel-load data.
- uio_out  output  8  constant 8'h00.
- uio_oe  output  8  constant 8'h00; all bidirectional pins are inputs.

Interface constraint (already decided): one clock; reset is synchronous and active-high.

Behaviour:
- State: one WIDTH-bit register, count. uo_out = count directly, with no combinational path from inputs to uo_out.
- Reset: at any rising clk edge with rst = 1, count <= RESET_VALUE (0x00).
  - Reset overrides all other inputs.
  - Mid-count reset returns count to 0 on that edge.
  - uio_out and uio_oe are 0x00 at all times, including during reset.
- Priority at each rising edge, highest first:
  - rst = 1: count <= 0.
  - ena = 0: hold.
  - load (ui_in[2]) = 1: count <= uio_in. Load beats counting, regardless of count_en and up_down.
  - count_en (ui_in[0]) = 1 and up_down = 1: count <= count + 1, modulo 256.
  - count_en = 1 and up_down = 0: count <= count - 1, modulo 256.
  - Otherwise: hold.
- Latency: one cycle. Inputs sampled at edge N appear on uo_out just after edge N.
- Wrap-around: up from 0xFF gives 0x00; down from 0x00 gives 0xFF. No saturation and no sticky flag.
- Direction change takes effect on the next edge, with no dead cycle.
- Unused bits ui_in[7:3] are ignored. X/Z on unused bits must not affect count.
- No internal clock gating; the enable is implemented as a register hold.

Decomposition:
- Shared package updown_counter_pkg holds:
  - WIDTH
  - RESET_VALUE
  - bit-index constants for the ui_in fields: CNT_EN_BIT = 0, UP_DOWN_BIT = 1, LOAD_BIT = 2
- One sub-module is natural: updown_counter_core.
  - Ports: clk, rst, en, load, up, d[WIDTH-1:0], q[WIDTH-1:0].
  - Contains the register and the next-state mux.
- The top level only decodes ui_in, ties off uio_out and uio_oe, and maps q to uo_out.

Test Plan:
- Reset: hold rst = 1 for 2 cycles with ui_in = 0x03 -> uo_out = 0x00 after the first edge and stays 0x00.
- Count up: rst = 0, ena = 1, ui_in = 0x03 for 10 edges from 0 -> uo_out steps 1,2,…,10 and ends at 0x0A.
- Count down then disable:
  - ui_in = 0x01 for 10 edges from 0x0A -> uo_out = 0x00.
  - Then ui_in = 0x00 for 5 edges -> uo_out stays 0x00.
- Wrap-around:
  - From 0x00 with ui_in = 0x01, one edge -> 0xFF.
  - Then ui_in = 0x03, one edge -> 0x00.
- Load priority: uio_in = 0xA5, ui_in = 0x07 for one edge -> 0xA5; then ui_in = 0x03 for 2 edges -> 0xA7.
- Enable and reset override:
  - ena = 0 with ui_in = 0x03 for 4 edges -> count unchanged.
  - From count 0x40 with ena = 1, assert rst together with load = 1 -> 0x00.
  - Check uio_oe = uio_out = 0x00 throughout.

Source files
------------

// File: rtl/updown_counter_pkg.sv
// updown_counter_pkg
// Shared constants for the up/down counter:
//   WIDTH        counter width, equal to the uo_out width of the wrapper
//   RESET_VALUE  count value loaded by reset
//   *_BIT        bit positions of the control fields inside ui_in
package updown_counter_pkg;

    localparam int unsigned WIDTH = 8;
    localparam logic [WIDTH-1:0] RESET_VALUE = 8'h00;

    localparam int unsigned CNT_EN_BIT  = 0;
    localparam int unsigned UP_DOWN_BIT = 1;
    localparam int unsigned LOAD_BIT    = 2;

endpackage : updown_counter_pkg

// File: rtl/updown_counter_if.sv
// updown_counter_if
// Pin bundle of the user-project wrapper (everything except clk/rst).
//   ena      design enable, 0 holds the count
//   ui_in    [0] count_en, [1] up_down (1 = up), [2] load, [7:3] unused
//   uo_out   registered count
//   uio_in   parallel-load data
//   uio_out  always 8'h00
//   uio_oe   always 8'h00 (bidirectional pins are inputs only)
// There is no valid/ready handshake on this bundle: the inputs are sampled
// on every rising clk edge and uo_out is valid at all times after reset.
// master: the side driving the inputs (harness); slave: the counter.
interface updown_counter_if;
    import updown_counter_pkg::*;

    logic             ena;
    logic [7:0]       ui_in;
    logic [WIDTH-1:0] uo_out;
    logic [7:0]       uio_in;
    logic [7:0]       uio_out;
    logic [7:0]       uio_oe;

    modport master (
        output ena,
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );

endinterface : updown_counter_if

// File: rtl/updown_counter_core.sv
// updown_counter_core
// Count register and its next-state mux.
//   clk   clock, rising edge
//   rst   synchronous active-high reset to RESET_VALUE
//   en    update enable; when 0 the register holds
//   load  when en=1: take d instead of counting
//   up    when en=1 and load=0: 1 = increment, 0 = decrement (modulo 2^WIDTH)
//   d     parallel-load data
//   q     current count, straight from the register
module updown_counter_core
    import updown_counter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             up,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load beats counting; the +/-1 wraps naturally in WIDTH bits.
    always_comb begin
        count_d = count_q;
        if (en) begin
            if (load) begin
                count_d = d;
            end else if (up) begin
                count_d = count_q + WIDTH'(1);
            end else begin
                count_d = count_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= RESET_VALUE;
        end else begin
            count_q <= count_d;
        end
    end

    assign q = count_q;

endmodule : updown_counter_core

// File: rtl/updown_counter.sv
// updown_counter
// 8-bit synchronous up/down counter in the user-project wrapper pin-out.
//   clk   clock, all state updates on the rising edge
//   rst   synchronous active-high reset, overrides everything
//   bus   wrapper pins (ena, ui_in, uo_out, uio_in, uio_out, uio_oe)
// Priority per edge: rst > ena=0 (hold) > load > count_en (up/down) > hold.
module updown_counter
    import updown_counter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    updown_counter_if.slave   bus
);

    logic             core_en;
    logic             core_load;
    logic             core_up;
    logic [WIDTH-1:0] core_q;

    // The core has a single enable, so both "load" and "count" requests
    // open it; ena gates both, which realises the hold-when-disabled rule
    // without touching the clock.
    assign core_en   = bus.ena & (bus.ui_in[LOAD_BIT] | bus.ui_in[CNT_EN_BIT]);
    assign core_load = bus.ui_in[LOAD_BIT];
    assign core_up   = bus.ui_in[UP_DOWN_BIT];

    updown_counter_core u_core (
        .clk  (clk),
        .rst  (rst),
        .en   (core_en),
        .load (core_load),
        .up   (core_up),
        .d    (bus.uio_in[WIDTH-1:0]),
        .q    (core_q)
    );

    assign bus.uo_out  = core_q;
    assign bus.uio_out = 8'h00;
    assign bus.uio_oe  = 8'h00;

    // ui_in[7:3] carry nothing; gathered here so they are visibly ignored.
    logic unused_ui;
    assign unused_ui = &{1'b0, bus.ui_in[7:3]};

endmodule : updown_counter

// File: tb/tb_updown_counter.sv
// tb_updown_counter
// Directed vectors with hand-computed expected counts. The driver pushes the
// expected uo_out for each edge into exp_q; the monitor pops and compares
// just after every rising edge, and also checks uio_out/uio_oe.
module tb_updown_counter;

    logic clk;
    logic rst;

    updown_counter_if bus ();

    updown_counter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_name_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        rst        = 1'b1;
        bus.ena    = 1'b0;
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h00;
    end

    // ---------------- driver ----------------
    // Apply one edge worth of inputs and record the count expected after it.
    task automatic drive(input logic r, input logic e, input logic [7:0] ui,
                         input logic [7:0] uio, input logic [7:0] exp);
        @(negedge clk);
        rst        = r;
        bus.ena    = e;
        bus.ui_in  = ui;
        bus.uio_in = uio;
        exp_q.push_back(exp);
        @(posedge clk);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [7:0] exp;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                tests_run++;
                if (bus.uo_out !== exp) begin
                    tests_failed++;
                    $display("FAIL uo_out: got %02h expected %02h at %0t", bus.uo_out, exp, $time);
                end
                tests_run++;
                if (bus.uio_out !== 8'h00 || bus.uio_oe !== 8'h00) begin
                    tests_failed++;
                    $display("FAIL uio_tieoff: uio_out=%02h uio_oe=%02h expected 00/00 at %0t",
                             bus.uio_out, bus.uio_oe, $time);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset held for 2 edges while asking to count up
        drive(1'b1, 1'b1, 8'h03, 8'h00, 8'h00);
        drive(1'b1, 1'b1, 8'h03, 8'h00, 8'h00);

        // Count up 1..10
        for (int i = 1; i <= 10; i++) drive(1'b0, 1'b1, 8'h03, 8'h00, 8'(i));

        // Count down 9..0
        for (int i = 9; i >= 0; i--) drive(1'b0, 1'b1, 8'h01, 8'h00, 8'(i));

        // Counting disabled: hold at 0
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 8'h00, 8'h00, 8'h00);

        // Wrap-around both ways
        drive(1'b0, 1'b1, 8'h01, 8'h00, 8'hFF);
        drive(1'b0, 1'b1, 8'h03, 8'h00, 8'h00);

        // Load beats counting, then count up from loaded value
        drive(1'b0, 1'b1, 8'h07, 8'hA5, 8'hA5);
        drive(1'b0, 1'b1, 8'h03, 8'hA5, 8'hA6);
        drive(1'b0, 1'b1, 8'h03, 8'hA5, 8'hA7);

        // ena=0 holds despite count request and despite load request
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 8'h03, 8'h00, 8'hA7);
        drive(1'b0, 1'b0, 8'h04, 8'h5A, 8'hA7);

        // Load while count_en=1 and down selected
        drive(1'b0, 1'b1, 8'h05, 8'h3C, 8'h3C);
        // Unused bits set, count down: 3C -> 3B
        drive(1'b0, 1'b1, 8'hF9, 8'h00, 8'h3B);
        // Direction change without dead cycle
        drive(1'b0, 1'b1, 8'h03, 8'h00, 8'h3C);
        drive(1'b0, 1'b1, 8'h01, 8'h00, 8'h3B);

        // Load 0x40, then reset together with load wins
        drive(1'b0, 1'b1, 8'h04, 8'h40, 8'h40);
        drive(1'b1, 1'b1, 8'h07, 8'hA5, 8'h00);
        drive(1'b0, 1'b1, 8'h03, 8'h00, 8'h01);

        // Bounded drain of the scoreboard
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: %0d expected values never checked, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global watchdog
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule : tb_updown_counter
